// File: rtl/snake_grid_builder_pkg.sv
// Shared types and helpers for the snake occupancy-grid builder.
// Field positions follow the snake list word {x, y, active}: x in the MSBs, active in bit 0.
package snake_grid_builder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_SWAP
    } state_t;

    localparam int ACTIVE_BIT = 0;
    localparam int Y_LSB      = 1;

    // Ceiling log2; callers pass sizes of at least 2.
    function automatic int logb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/snake_grid_builder_if.sv
// Bus between the grid builder, the snake list memory and the VGA renderer.
// master = system side (start, list memory, renderer); slave = grid builder.
interface snake_grid_builder_if
    import snake_grid_builder_pkg::*;
#(
    parameter int H = 32,
    parameter int V = 32
);
    localparam int X_BITS    = logb2(H);
    localparam int Y_BITS    = logb2(V);
    localparam int ADDR_BITS = logb2(H * V);

    logic                        start;
    logic [ADDR_BITS-1:0]        list_addr;
    logic [X_BITS+Y_BITS:0]      list_data;
    logic [X_BITS-1:0]           query_x;
    logic [Y_BITS-1:0]           query_y;
    logic                        query_hit;
    logic                        busy;
    logic                        done;
    logic [ADDR_BITS:0]          seg_count;

    modport master (
        output start, list_data, query_x, query_y,
        input  list_addr, query_hit, busy, done, seg_count
    );

    modport slave (
        input  start, list_data, query_x, query_y,
        output list_addr, query_hit, busy, done, seg_count
    );

endinterface

// File: rtl/snake_bitmap_bank.sv
// One V x H occupancy bitmap: whole-row clear, single-bit set, registered bit read.
// Cell (x, y) lives in bit x of row y.
module snake_bitmap_bank
    import snake_grid_builder_pkg::*;
#(
    parameter int H = 32,
    parameter int V = 32
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_en,
    input  logic [logb2(V)-1:0]  clr_row,
    input  logic                 set_en,
    input  logic [logb2(H)-1:0]  set_x,
    input  logic [logb2(V)-1:0]  set_y,
    input  logic [logb2(H)-1:0]  rd_x,
    input  logic [logb2(V)-1:0]  rd_y,
    output logic                 rd_bit
);
    localparam int YB = logb2(V);

    logic [H-1:0] rows [V];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < V; r++) rows[r] <= '0;
            rd_bit <= 1'b0;
        end else begin
            // Clear wins over set; the controller never asks for both at once.
            for (int r = 0; r < V; r++) begin
                if (clr_en && clr_row == YB'(r)) begin
                    rows[r] <= '0;
                end else if (set_en && set_y == YB'(r)) begin
                    rows[r][set_x] <= 1'b1;
                end
            end
            rd_bit <= rows[rd_y][rd_x];
        end
    end

endmodule

// File: rtl/snake_grid_builder.sv
// Builds a double-buffered occupancy bitmap from the snake segment list on each end-of-shift.
// The renderer only ever reads the front bank; all writes go to the back bank.
module snake_grid_builder
    import snake_grid_builder_pkg::*;
#(
    parameter int H = 32,
    parameter int V = 32
)(
    input  logic               clk,
    input  logic               reset,
    snake_grid_builder_if.slave bus
);
    localparam int XB    = logb2(H);
    localparam int YB    = logb2(V);
    localparam int AB    = logb2(H * V);
    localparam int CELLS = H * V;
    localparam int X_LSB = Y_LSB + YB;

    localparam logic [AB-1:0] LAST_ADDR = AB'(CELLS - 1);
    localparam logic [YB-1:0] LAST_ROW  = YB'(V - 1);
    localparam logic [XB:0]   H_LIM     = (XB + 1)'(H);
    localparam logic [YB:0]   V_LIM     = (YB + 1)'(V);

    state_t          state, state_nxt;
    logic [YB-1:0]   row_cnt;
    logic [AB-1:0]   list_addr;
    logic [AB-1:0]   addr_p0;
    logic            vld_p0;
    logic [AB:0]     scan_cnt;
    logic            front_sel;
    logic            busy;
    logic            done;
    logic [AB:0]     seg_count;

    logic            smp_active;
    logic [XB-1:0]   smp_x;
    logic [YB-1:0]   smp_y;
    logic            smp_in_range;
    logic            smp_take;
    logic            smp_end;
    logic            clearing;
    logic            rd_bit0, rd_bit1;

    assign smp_active   = bus.list_data[ACTIVE_BIT];
    assign smp_y        = bus.list_data[Y_LSB +: YB];
    assign smp_x        = bus.list_data[X_LSB +: XB];
    assign smp_in_range = ({1'b0, smp_x} < H_LIM) && ({1'b0, smp_y} < V_LIM);

    // vld_p0/addr_p0 describe the list_data sample now on the bus (address issued last cycle).
    assign smp_take = (state == ST_SCAN) && vld_p0 && smp_active && smp_in_range;
    assign smp_end  = (state == ST_SCAN) && vld_p0 && (!smp_active || addr_p0 == LAST_ADDR);
    assign clearing = (state == ST_CLEAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start)          state_nxt = ST_CLEAR;
            ST_CLEAR: if (row_cnt == LAST_ROW) state_nxt = ST_SCAN;
            ST_SCAN:  if (smp_end)            state_nxt = ST_SWAP;
            ST_SWAP:                          state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt   <= '0;
            list_addr <= '0;
            addr_p0   <= '0;
            vld_p0    <= 1'b0;
            scan_cnt  <= '0;
            front_sel <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            seg_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        row_cnt  <= '0;
                        scan_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    row_cnt   <= row_cnt + 1'b1;
                    list_addr <= '0;
                    vld_p0    <= 1'b0;
                end
                // ---- list read stage: address out now, sample arrives next cycle ----
                ST_SCAN: begin
                    vld_p0  <= 1'b1;
                    addr_p0 <= list_addr;
                    if (list_addr != LAST_ADDR) list_addr <= list_addr + 1'b1;
                    if (smp_take) scan_cnt <= scan_cnt + 1'b1;
                end
                ST_SWAP: begin
                    front_sel <= ~front_sel;
                    seg_count <= scan_cnt;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Bank 0 is the back buffer while front_sel=1, bank 1 while front_sel=0.
    snake_bitmap_bank #(.H(H), .V(V)) u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .clr_en  (clearing && front_sel),
        .clr_row (row_cnt),
        .set_en  (smp_take && front_sel),
        .set_x   (smp_x),
        .set_y   (smp_y),
        .rd_x    (bus.query_x),
        .rd_y    (bus.query_y),
        .rd_bit  (rd_bit0)
    );

    snake_bitmap_bank #(.H(H), .V(V)) u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .clr_en  (clearing && !front_sel),
        .clr_row (row_cnt),
        .set_en  (smp_take && !front_sel),
        .set_x   (smp_x),
        .set_y   (smp_y),
        .rd_x    (bus.query_x),
        .rd_y    (bus.query_y),
        .rd_bit  (rd_bit1)
    );

    // Both banks sample the query every cycle; selecting with the updated front_sel
    // makes a query taken on the swap edge return the new frame.
    assign bus.query_hit = front_sel ? rd_bit1 : rd_bit0;
    assign bus.list_addr = list_addr;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.seg_count = seg_count;

endmodule

// File: doc/snake_grid_builder.md
Name: snake_grid_builder

Overview:
- Reads the snake segment list memory, whose entries are {x, y, active}, and builds a double-buffered H×V occupancy bitmap for the VGA renderer.
- Started by the snake's end-of-shift pulse. Walks the list from address 0 until the first inactive entry, then swaps buffers.
- The renderer queries the front buffer per pixel cell with 1-cycle latency.

Parameters:
- H, 32, grid width in cells; xBits = logb2(H).
- V, 32, grid height in cells; yBits = logb2(V).
- addrBits = logb2(H*V), derived localparam, list address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse, connected to the snake's end_shift.
- list_addr  out  addrBits  read address into the snake list memory (port B).
- list_data  in  xBits+yBits+1  {x, y, active}; valid 1 cycle after list_addr.
- query_x  in  xBits  cell column asked by the renderer.
- query_y  in  yBits  cell row asked by the renderer.
- query_hit  out  1  registered: front-buffer bit at (query_x, query_y).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the new buffer becomes front.
- seg_count  out  addrBits+1  active segments in the current front buffer.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE; list_addr 0; busy 0; done 0; query_hit 0; seg_count 0; front_sel 0.
  - Both bitmaps all-zero; internal counters 0.
- Bitmaps: two arrays of V rows × H bits.
  - front = buf[front_sel]; back = buf[~front_sel].
  - Cell (x, y) is bit x of row y.
- IDLE:
  - start=1 → CLEAR, row counter 0, busy=1 next cycle.
  - start is ignored in every state other than IDLE; no queueing.
- CLEAR:
  - Zeroes one back row per cycle, V cycles total.
  - After the last row → SCAN, with list_addr=0 and data_valid pipe flag cleared.
- SCAN:
  - list_addr increments each cycle, saturating at H*V-1.
  - A 1-stage valid flag marks which list_data sample belongs to the previous address.
  - On a valid sample with active=1 and x<H and y<V: set back[y][x] and increment the scan counter.
  - Active entries with out-of-range coordinates are skipped and not counted.
  - On a valid sample with active=0 → SWAP; remaining list entries are not read.
  - If the sample for address H*V-1 arrives with active=1, it is processed, then → SWAP.
  - Duplicate coordinates (self-collision frame) set the same bit once but are counted every time.
- SWAP (1 cycle):
  - front_sel toggles; seg_count ← scan counter; done=1; busy=0 at the next edge.
  - Then → IDLE.
- Timing, with start sampled at cycle 0 and list length L:
  - L < H*V: done is high at cycle V+L+3.
  - L = H*V: done is high at cycle V+H*V+2.
  - L = 0: done at V+3, front buffer empty, seg_count 0.
- Query path:
  - query_hit ← front[query_y][query_x] every cycle (1-cycle latency), independent of state.
  - The front buffer is never modified outside reset, so the renderer never sees a partial frame.
  - Swap edge: a query sampled on the SWAP edge returns the new front buffer.
- Reset mid-scan: everything returns to reset values immediately. The next start rebuilds from scratch.
- Widths:
  - The scan counter is addrBits+1 bits so it can hold H*V.
  - Coordinate compares are unsigned.

Decomposition:
- Shared package: logb2 function; field-slice constants for {x, y, active} matching the snake list format (x in MSBs, active in bit 0).
- One natural sub-module: snake_bitmap_bank. It is a single V×H bitmap with:
  - row-clear port;
  - single-bit set port;
  - registered bit read port.
- Instantiate it twice. The FSM and counters stay in the top.

Test Plan:
- Reset (reset=0), then release → all outputs 0; query every cell → query_hit=0.
- H=V=8, list {(4,4,1),(3,4,1),(2,4,1),(x,x,0)}, start → done at cycle 8+3+3=14; seg_count=3; hits at (2..4,4), all other cells 0.
- Second frame with list {(5,4,1),(4,4,1),(3,4,1),(0,0,0)} → before done, query (2,4)=1; after done, (2,4)=0 and (5,4)=1; no cycle shows a mixed frame.
- Full list, 64 distinct active entries with H=V=8 → done at cycle 8+64+2=74; seg_count=64; all cells 1; list_addr holds 63.
- start pulsed again while busy, then reset=0 asserted mid-SCAN → the extra start is ignored. On reset, busy=0 immediately and bitmaps are zero. A new start completes normally.
- Duplicate entry (4,4) twice with L=2 → seg_count=2; only (4,4) set.
